// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers for the EX stage.
// Fixed latency: one bit per cycle for WIDTH cycles, plus one sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             divideByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int COUNT_BITS = $clog2(WIDTH) + 1;
  localparam logic [COUNT_BITS-1:0] LAST_COUNT = COUNT_BITS'(WIDTH - 1);

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t                  state, state_next;
  logic [COUNT_BITS-1:0]   count;
  logic [2*WIDTH-1:0]      acc;
  logic [WIDTH-1:0]        mag_b;
  logic                    is_div;
  logic                    neg_main;
  logic                    neg_rem;
  logic                    div_zero;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic is_signed);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return (is_signed && sv[WIDTH-1]) ? -sv : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v,
                                             input logic en);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return en ? -sv : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v,
                                                input logic en);
    logic signed [2*WIDTH-1:0] sv;
    sv = v;
    return en ? -sv : v;
  endfunction

  logic             accept;
  logic             op_signed;
  logic             sign_a, sign_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  assign accept    = (state == IDLE) && start && !flush;
  assign op_signed = !operation[0];
  assign sign_a    = op_signed && operandA[WIDTH-1];
  assign sign_b    = op_signed && operandB[WIDTH-1];
  assign busy      = (state != IDLE);

  // Multiply: add multiplier into upper half when LSB set, then shift right.
  // Divide: shift remainder:dividend left, subtract divisor when it fits.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : '0)};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    div_diff  = div_shift - {1'b0, mag_b};
    if (is_div)
      acc_next = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
    else
      acc_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Sign correction applied on the way out; a zero divisor forces LO to all
  // ones while the sign-restored remainder already equals the original rs.
  always_comb begin
    prod_fix = neg_2w(acc, neg_main);
    if (is_div) begin
      fin_hi = neg_w(acc[2*WIDTH-1:WIDTH], neg_rem);
      fin_lo = div_zero ? '1 : neg_w(acc[WIDTH-1:0], neg_main);
    end else begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !operation[2]) state_next = RUN;
      RUN:     if (flush) state_next = IDLE;
               else if (count == LAST_COUNT) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      acc      <= '0;
      mag_b    <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (accept && !operation[2]) begin
      count    <= '0;
      acc      <= {{WIDTH{1'b0}}, magnitude(operandA, op_signed)};
      mag_b    <= magnitude(operandB, op_signed);
      is_div   <= operation[1];
      neg_main <= sign_a ^ sign_b;
      neg_rem  <= sign_a;
      div_zero <= operation[1] && (operandB == '0);
    end else if (state == RUN) begin
      count <= count + 1'b1;
      acc   <= acc_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi           <= '0;
      lo           <= '0;
      done         <= 1'b0;
      divideByZero <= 1'b0;
    end else begin
      done         <= 1'b0;
      divideByZero <= 1'b0;
      if (state == FINISH && !flush) begin
        hi           <= fin_hi;
        lo           <= fin_lo;
        done         <= 1'b1;
        divideByZero <= div_zero;
      end else if (accept && operation == OP_MTHI) begin
        hi <= operandA;
      end else if (accept && operation == OP_MTLO) begin
        lo <= operandA;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed vectors.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  operation;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        flush;
  logic        busy;
  logic        done;
  logic        divideByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .operation(operation),
    .operandA(operandA), .operandB(operandB), .flush(flush), .busy(busy),
    .done(done), .divideByZero(divideByZero), .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; launches the op, then waits for busy to drop.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_dz);
    int n;
    start = 1'b1; operation = op; operandA = a; operandB = b;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'd33);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_dz"}, 64'(divideByZero), 64'(exp_dz));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int seen_done;
    int seen_busy;
    reset = 1'b0; start = 1'b0; operation = 3'd0;
    operandA = '0; operandB = '0; flush = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(divideByZero), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    // MTHI then MTLO on consecutive edges
    start = 1'b1; operation = 3'd4; operandA = 32'hAAAA0000;
    @(negedge clock);
    seen_busy = int'(busy);
    operation = 3'd5; operandA = 32'h00005555;
    @(negedge clock);
    start = 1'b0;
    seen_busy += int'(busy);
    check("mt_busy", 64'(seen_busy), 64'd0);
    check("mthi_hi", 64'(hi), 64'hAAAA0000);
    check("mtlo_lo", 64'(lo), 64'h00005555);

    // Reserved operation is ignored
    start = 1'b1; operation = 3'd6; operandA = 32'h11111111; operandB = 32'h2;
    @(negedge clock);
    start = 1'b0;
    check("rsv_busy", 64'(busy), 64'd0);
    check("rsv_hi", 64'(hi), 64'hAAAA0000);
    check("rsv_lo", 64'(lo), 64'h00005555);

    // flush beats start while idle
    start = 1'b1; flush = 1'b1; operation = 3'd4; operandA = 32'h12345678;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    check("flush_idle_hi", 64'(hi), 64'hAAAA0000);
    check("flush_idle_busy", 64'(busy), 64'd0);

    // Back-to-back: each new op is launched in the done cycle of the last
    run_op("mult",   3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("multu",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("divu",   3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    run_op("div_neg",3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf",3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("div_z",  3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run_op("divu_z", 3'd3, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1);
    @(negedge clock);
    check("done_pulse_end", 64'(done), 64'd0);
    check("dz_pulse_end", 64'(divideByZero), 64'd0);

    // Flush mid-multiply; a start during RUN must be ignored
    start = 1'b1; operation = 3'd0; operandA = 32'd5; operandB = 32'd3;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    start = 1'b1; operation = 3'd4; operandA = 32'hDEADBEEF;
    @(negedge clock);
    start = 1'b0;
    check("run_busy", 64'(busy), 64'd1);
    repeat (4) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      seen_done += int'(done);
      @(negedge clock);
    end
    check("flush_no_done", 64'(seen_done), 64'd0);
    check("flush_hi", 64'(hi), 64'h00001234);
    check("flush_lo", 64'(lo), 64'hFFFFFFFF);

    // Reset mid-divide
    start = 1'b1; operation = 3'd2; operandA = 32'd100; operandB = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      seen_done += int'(done);
      @(negedge clock);
    end
    check("mid_rst_no_done", 64'(seen_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers.
- Sits beside the EX stage of the 5-stage pipeline. It adds MULT/MULTU/DIV/DIVU/MTHI/MTLO, which the current ALU path lacks.
- The ID stage launches operations with start. It stalls dependent MFHI/MFLO using busy, and flushes in-flight work on redirect.
- Latency is data-independent so that hazard logic stays simple.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits; must be even and >= 4.
- COUNT_BITS, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  launch request, sampled on clock edge
- operation  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=reserved
- operandA  input  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
- operandB  input  WIDTH  rt value (multiplier / divisor)
- flush  input  1  abort in-flight operation
- busy  output  1  high while an operation is iterating or finishing
- done  output  1  one-cycle pulse when HI/LO are updated by a mul/div
- divideByZero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with operandB==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; hi=0, lo=0, busy=0, done=0, divideByZero=0.
  - Counter and working registers are cleared.
  - Reset asserted mid-operation discards the operation; no done pulse is produced.
- States: IDLE -> RUN -> FINISH -> IDLE.
- Operation accept:
  - An operation is accepted only at an edge where state==IDLE, start==1 and flush==0.
  - start in RUN or FINISH is ignored. No queueing; the caller must hold off until busy==0.
- MTHI/MTLO:
  - At the accepting edge, hi (or lo) <= operandA. State stays IDLE.
  - busy stays 0; no done pulse.
- Reserved operations (6, 7): ignored, no state change.
- MULT/DIV accept:
  - At the accepting edge, latch |operandA| and |operandB|. Absolute value applies only for the signed ops; unsigned ops use the raw values.
  - Latch the result signs:
    - product and quotient sign = signA ^ signB;
    - remainder sign = signA.
  - Go to RUN with counter=0 and busy=1.
- RUN:
  - One bit per cycle for exactly WIDTH cycles, then go to FINISH.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract giving a WIDTH quotient and a WIDTH remainder.
- FINISH (one cycle):
  - Apply sign correction: two's-complement negate the 2*WIDTH product, or negate the quotient and remainder independently.
  - At the leaving edge:
    - multiply: hi <= product[2W-1:W], lo <= product[W-1:0];
    - divide: hi <= remainder, lo <= quotient.
  - done=1 for exactly the following cycle; busy=0 from that same cycle.
- Latency: accept edge E0 -> hi/lo valid and done=1 after edge E0+WIDTH+1. A new start is accepted on the edge at which done is high.
- Divide by zero:
  - The operation still takes full latency.
  - Result: lo = all ones, hi = operandA (original, unsigned-interpreted).
  - divideByZero pulses with done.
- Signed overflow (DIV MIN / -1): lo=MIN, hi=0, with no special flag. This falls out of the magnitude method.
- Flush:
  - In RUN or FINISH, go to IDLE at the next edge; busy=0; hi/lo unchanged; no done.
  - flush and start on the same edge while IDLE: flush wins and nothing is accepted.
- hi/lo change only at FINISH exit or on MTHI/MTLO; otherwise they hold.

Test Plan:
- MULT, A=0xFFFFFFFD (-3), B=7 -> busy for 33 cycles, then done; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. DIVU, A=100, B=7 -> lo=14, hi=2.
- DIV, A=-7 (0xFFFFFFF9), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV, A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU, A=0x1234, B=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x1234; done and divideByZero high the same cycle.
- Start MULT, pulse flush at cycle 10 -> busy=0 next cycle; no done; hi/lo keep prior values. A second start asserted at cycle 5 (before the flush) is ignored.
- MTHI A=0xAAAA0000 then MTLO A=0x5555 on consecutive cycles -> hi=0xAAAA0000, lo=0x5555; busy never asserts. Drive reset low mid-DIV -> hi=lo=0, busy=0 immediately.
